// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between NUM_REQ masters; a grant lasts a whole cyc.
// Optional stall watchdog enabled with `define WB_ARB_TIMEOUT_EN (terminates stalled beats with err).
module wb_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NUM_REQ-1:0]       req_cyc_i,
    input  logic [NUM_REQ-1:0]       req_stb_i,
    input  logic [NUM_REQ-1:0]       req_we_i,
    input  logic [NUM_REQ*DW/8-1:0]  req_sel_i,
    input  logic [NUM_REQ*AW-1:0]    req_adr_i,
    input  logic [NUM_REQ*DW-1:0]    req_dat_i,
    output logic [NUM_REQ-1:0]       req_ack_o,
    output logic [NUM_REQ-1:0]       req_err_o,
    output logic [DW-1:0]            req_dat_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [DW/8-1:0]          s_sel_o,
    output logic [AW-1:0]            s_adr_o,
    output logic [DW-1:0]            s_dat_o,
    input  logic                     s_ack_i,
    input  logic [DW-1:0]            s_dat_i,
    output logic [NUM_REQ-1:0]       grant_o
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gidx;
    logic               busy;
    logic               abort;

    logic               gnt_cyc, gnt_stb, gnt_we;
    logic [SW-1:0]      gnt_sel;
    logic [AW-1:0]      gnt_adr;
    logic [DW-1:0]      gnt_dat;

    // First requesting index at or after ptr, walking the ring once.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] cyc,
                                                   input logic [IW-1:0]      ptr);
        logic [NUM_REQ-1:0] onehot;
        logic               found;
        logic [IW-1:0]      idx;
        onehot = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            if (!found && cyc[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        return onehot;
    endfunction

    assign busy = (state_q == ST_BUSY);

    always_comb begin
        gidx    = '0;
        gnt_cyc = 1'b0;
        gnt_stb = 1'b0;
        gnt_we  = 1'b0;
        gnt_sel = '0;
        gnt_adr = '0;
        gnt_dat = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                gidx    = IW'(k);
                gnt_cyc = req_cyc_i[k];
                gnt_stb = req_stb_i[k];
                gnt_we  = req_we_i[k];
                gnt_sel = req_sel_i[k*SW +: SW];
                gnt_adr = req_adr_i[k*AW +: AW];
                gnt_dat = req_dat_i[k*DW +: DW];
            end
        end
    end

    assign s_cyc_o   = busy & gnt_cyc;
    assign s_stb_o   = busy & gnt_stb & ~abort;
    assign s_we_o    = busy & gnt_we;
    assign s_sel_o   = busy ? gnt_sel : '0;
    assign s_adr_o   = busy ? gnt_adr : '0;
    assign s_dat_o   = busy ? gnt_dat : '0;
    assign req_dat_o = s_dat_i;
    assign grant_o   = grant_q;
    assign req_ack_o = (busy && s_ack_i && !wb_rst_i) ? grant_q : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (state_q == ST_IDLE) begin
            if (|req_cyc_i) begin
                grant_d = rr_pick(req_cyc_i, ptr_q);
                state_d = ST_BUSY;
            end
        end else begin
            // Release only when the owner ends its cycle; stb gaps inside a block keep the grant.
            if (!gnt_cyc) begin
                grant_d = '0;
                state_d = ST_IDLE;
                ptr_d   = IW'((int'(gidx) + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = 16;

    logic [CW-1:0] wdog_q, wdog_d;
    logic          abort_q, abort_d;
    logic          stall, tmo;

    assign stall = busy & s_stb_o & ~s_ack_i;
    // Error fires on the TIMEOUT-th consecutive stalled cycle itself.
    assign tmo   = stall & (wdog_q == CW'(TIMEOUT - 1));

    always_comb begin
        wdog_d  = wdog_q;
        abort_d = abort_q;
        if (!busy || !gnt_cyc) begin
            wdog_d  = '0;
            abort_d = 1'b0;
        end else if (abort_q) begin
            wdog_d = '0;
            if (!gnt_stb) begin
                abort_d = 1'b0;
            end
        end else if (tmo) begin
            wdog_d  = '0;
            abort_d = 1'b1;
        end else if (s_ack_i) begin
            wdog_d = '0;
        end else if (stall) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wdog_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            abort_q <= abort_d;
        end
    end

    assign abort     = abort_q;
    assign req_err_o = (tmo && !wb_rst_i) ? grant_q : '0;
`else
    assign abort     = 1'b0;
    assign req_err_o = {NUM_REQ{TIMEOUT < 0}};
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed masters push expected acks/grants, a monitor pops on DUT activity.
module tb_wb_port_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]    req_cyc, req_stb, req_we, req_ack, req_err, grant;
    logic [NUM_REQ*SW-1:0] req_sel;
    logic [NUM_REQ*AW-1:0] req_adr;
    logic [NUM_REQ*DW-1:0] req_dat_w;
    logic [DW-1:0]         req_dat_r;
    logic                  s_cyc, s_stb, s_we, s_ack;
    logic [SW-1:0]         s_sel;
    logic [AW-1:0]         s_adr;
    logic [DW-1:0]         s_dat_w, s_dat_r;

    logic          m_cyc [NUM_REQ];
    logic          m_stb [NUM_REQ];
    logic          m_we  [NUM_REQ];
    logic [SW-1:0] m_sel [NUM_REQ];
    logic [AW-1:0] m_adr [NUM_REQ];
    logic [DW-1:0] m_dat [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_cyc[k]              = m_cyc[k];
            req_stb[k]              = m_stb[k];
            req_we[k]               = m_we[k];
            req_sel[k*SW +: SW]     = m_sel[k];
            req_adr[k*AW +: AW]     = m_adr[k];
            req_dat_w[k*DW +: DW]   = m_dat[k];
        end
    end

    wb_port_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .req_cyc_i(req_cyc),
        .req_stb_i(req_stb),
        .req_we_i (req_we),
        .req_sel_i(req_sel),
        .req_adr_i(req_adr),
        .req_dat_i(req_dat_w),
        .req_ack_o(req_ack),
        .req_err_o(req_err),
        .req_dat_o(req_dat_r),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_sel_o  (s_sel),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_dat_w),
        .s_ack_i  (s_ack),
        .s_dat_i  (s_dat_r),
        .grant_o  (grant)
    );

    // Slave: acks two cycles after it first sees stb, or never when disabled.
    logic          slave_en = 1'b1;
    logic          slave_ack = 1'b0;
    logic          force_ack = 1'b0;
    logic [1:0]    scnt = '0;
    logic [DW-1:0] slave_rdata = '0;

    always @(posedge clk) begin
        if (rst || !slave_en) begin
            scnt      <= '0;
            slave_ack <= 1'b0;
        end else if (slave_ack) begin
            scnt      <= '0;
            slave_ack <= 1'b0;
        end else if (s_cyc && s_stb) begin
            if (scnt == 2'd1) slave_ack <= 1'b1;
            else              scnt      <= scnt + 2'd1;
        end else begin
            scnt <= '0;
        end
    end

    assign s_ack   = slave_ack | force_ack;
    assign s_dat_r = s_ack ? slave_rdata : 32'hDEAD_BEEF;

    typedef struct {
        logic [NUM_REQ-1:0] ack;
        logic [AW-1:0]      adr;
        logic [DW-1:0]      wdat;
        logic [SW-1:0]      sel;
        logic               we;
        logic [DW-1:0]      rdat;
    } exp_t;

    exp_t               ack_q[$];
    logic [NUM_REQ-1:0] gnt_q[$];
    int                 n_cmp  = 0;
    int                 n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic expired(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic exp_t mk(input logic [NUM_REQ-1:0] ack, input logic [AW-1:0] adr,
                                input logic [DW-1:0] wdat, input logic [SW-1:0] sel,
                                input logic we, input logic [DW-1:0] rdat);
        exp_t e;
        e.ack = ack; e.adr = adr; e.wdat = wdat; e.sel = sel; e.we = we; e.rdat = rdat;
        return e;
    endfunction

    exp_t               mon_e;
    logic [NUM_REQ-1:0] gnt_prev = '0;

    initial forever begin
        @(negedge clk);
        if (req_ack != '0) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", 64'(req_ack), 64'd0);
            end else begin
                mon_e = ack_q.pop_front();
                check("ack_vec",   64'(req_ack), 64'(mon_e.ack));
                check("ack_grant", 64'(grant),   64'(mon_e.ack));
                check("ack_adr",   64'(s_adr),   64'(mon_e.adr));
                check("ack_we",    64'(s_we),    64'(mon_e.we));
                check("ack_sel",   64'(s_sel),   64'(mon_e.sel));
                if (mon_e.we) check("ack_wdat", 64'(s_dat_w),   64'(mon_e.wdat));
                else          check("ack_rdat", 64'(req_dat_r), 64'(mon_e.rdat));
            end
        end
        if (grant != '0 && gnt_prev == '0) begin
            if (gnt_q.size() == 0) check("unexpected_grant", 64'(grant), 64'd0);
            else                   check("grant_order", 64'(grant), 64'(gnt_q.pop_front()));
        end
        gnt_prev = grant;
    end

    task automatic wait_ack(input int k, input string name);
        bit got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (req_ack[k]) got = 1'b1;
        end
        if (!got) expired(name);
    endtask

    task automatic xfer(input int k, input logic we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] dat, input logic [SW-1:0] sel, input int beats);
        @(posedge clk); #1;
        m_cyc[k] = 1'b1;
        for (int b = 0; b < beats; b++) begin
            m_stb[k] = 1'b1;
            m_we[k]  = we;
            m_adr[k] = adr + AW'(4 * b);
            m_dat[k] = dat;
            m_sel[k] = sel;
            wait_ack(k, "xfer_ack_timeout");
            @(posedge clk); #1;
        end
        m_stb[k] = 1'b0;
        m_we[k]  = 1'b0;
        m_cyc[k] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    initial begin
        #200000;
        expired("global_time_limit");
        summary();
        $finish;
    end

    initial begin
        int bad_gnt, bad_err, bad_ack;
        bit got;
        for (int k = 0; k < NUM_REQ; k++) begin
            m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_we[k] = 1'b0;
            m_sel[k] = '0;   m_adr[k] = '0;   m_dat[k] = '0;
        end

        // Reset state, with a requester already asking.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h1111_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_s_ctl", 64'({s_cyc, s_stb, s_we, s_sel}), 64'd0);
        check("rst_s_adr", 64'(s_adr), 64'd0);
        check("rst_ack_err", 64'({req_ack, req_err}), 64'd0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_adr[0] = '0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single management write with grant latency and release timing.
        ack_q.push_back(mk(2'b01, 32'h3000_0000, 32'h0000_AB60, 4'hF, 1'b1, 32'h0));
        gnt_q.push_back(2'b01);
        @(posedge clk); #1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[0] = 32'h3000_0000; m_dat[0] = 32'h0000_AB60; m_sel[0] = 4'hF;
        @(negedge clk);
        check("t1_grant_req_cycle", 64'(grant), 64'd0);
        @(negedge clk);
        check("t1_grant_next_cycle", 64'(grant), 64'b01);
        check("t1_s_cyc", 64'(s_cyc), 64'd1);
        wait_ack(0, "t1_ack_timeout");
        @(posedge clk); #1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
        @(negedge clk);
        check("t1_grant_held_drop_cycle", 64'(grant), 64'b01);
        check("t1_s_cyc_follows", 64'(s_cyc), 64'd0);
        @(negedge clk);
        check("t1_grant_released", 64'(grant), 64'd0);
        check("t1_idle_adr", 64'(s_adr), 64'd0);
        check("t1_idle_dat", 64'(s_dat_w), 64'd0);

        // Simultaneous requesters alternate from a fresh reset.
        do_reset();
        slave_rdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            gnt_q.push_back(2'b01);
            ack_q.push_back(mk(2'b01, 32'h3000_0100 + 32'(i * 16), 32'h0, 4'hF, 1'b0, 32'h1234_5678));
            gnt_q.push_back(2'b10);
            ack_q.push_back(mk(2'b10, 32'h3000_0200 + 32'(i * 16), 32'h0, 4'hF, 1'b0, 32'h1234_5678));
        end
        fork
            for (int i = 0; i < 4; i++) xfer(0, 1'b0, 32'h3000_0100 + 32'(i * 16), 32'h0, 4'hF, 1);
            for (int i = 0; i < 4; i++) xfer(1, 1'b0, 32'h3000_0200 + 32'(i * 16), 32'h0, 4'hF, 1);
        join
        repeat (2) @(posedge clk);

        // Block cycle on req1 is not preempted by req0.
        slave_rdata = 32'h0000_AB61;
        gnt_q.push_back(2'b10);
        gnt_q.push_back(2'b01);
        for (int b = 0; b < 4; b++)
            ack_q.push_back(mk(2'b10, 32'h3000_0300 + 32'(4 * b), 32'h0, 4'hF, 1'b0, 32'h0000_AB61));
        ack_q.push_back(mk(2'b01, 32'h3000_0400, 32'h0, 4'hF, 1'b0, 32'h0000_AB61));
        fork
            xfer(1, 1'b0, 32'h3000_0300, 32'h0, 4'hF, 4);
            begin
                repeat (2) @(posedge clk);
                xfer(0, 1'b0, 32'h3000_0400, 32'h0, 4'hF, 1);
            end
        join
        repeat (2) @(posedge clk);

        // Stray ack while idle is ignored.
        @(posedge clk); #1 force_ack = 1'b1;
        @(negedge clk);
        check("idle_ack_ignored", 64'(req_ack), 64'd0);
        @(posedge clk); #1 force_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_no_grant", 64'(grant), 64'd0);

        // Reset while req1 holds the grant with stb pending.
        slave_en = 1'b0;
        gnt_q.push_back(2'b10);
        @(posedge clk); #1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h3000_0500; m_sel[1] = 4'hF;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (grant == 2'b10) got = 1'b1;
        end
        if (!got) expired("t5_grant_wait");
        check("t5_stb_pending", 64'(s_stb), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("t5_no_ack_err_in_reset", 64'({req_ack, req_err}), 64'd0);
        @(negedge clk);
        check("t5_s_cyc_after_reset", 64'(s_cyc), 64'd0);
        check("t5_grant_after_reset", 64'(grant), 64'd0);
        #1;
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        slave_en = 1'b1;
        slave_rdata = 32'hC0DE_0001;
        gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b10);
        ack_q.push_back(mk(2'b01, 32'h3000_0600, 32'h0, 4'hF, 1'b0, 32'hC0DE_0001));
        ack_q.push_back(mk(2'b10, 32'h3000_0700, 32'h0, 4'hF, 1'b0, 32'hC0DE_0001));
        fork
            xfer(0, 1'b0, 32'h3000_0600, 32'h0, 4'hF, 1);
            xfer(1, 1'b0, 32'h3000_0700, 32'h0, 4'hF, 1);
        join
        repeat (2) @(posedge clk);

        // Stalled slave: held grant (no watchdog) or err at the TIMEOUT-th stalled cycle.
        slave_en = 1'b0;
        gnt_q.push_back(2'b01);
        @(posedge clk); #1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h3000_0800; m_sel[0] = 4'hF;
        @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
        begin
            int nstall = 0, nerr = 0, err_at = -1, stb_late = 0;
            logic [NUM_REQ-1:0] err_vec = '0;
            bad_ack = 0;
            for (int t = 0; t < 60; t++) begin
                @(negedge clk);
                if (err_at >= 0 && s_stb) stb_late++;
                if (s_stb) nstall++;
                if (req_ack != '0) bad_ack++;
                if (req_err != '0) begin
                    nerr++;
                    if (err_at < 0) begin
                        err_at  = nstall;
                        err_vec = req_err;
                    end
                end
            end
            check("tmo_err_cycle", 64'(err_at), 64'(TIMEOUT));
            check("tmo_err_vec", 64'(err_vec), 64'b01);
            check("tmo_err_single_pulse", 64'(nerr), 64'd1);
            check("tmo_stb_forced_low", 64'(stb_late), 64'd0);
            check("tmo_no_ack", 64'(bad_ack), 64'd0);
            check("tmo_grant_held", 64'(grant), 64'b01);
        end
`else
        bad_gnt = 0; bad_err = 0; bad_ack = 0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (grant !== 2'b01) bad_gnt++;
            if (req_err !== '0)  bad_err++;
            if (req_ack !== '0)  bad_ack++;
        end
        check("stall_grant_held", 64'(bad_gnt), 64'd0);
        check("stall_err_zero", 64'(bad_err), 64'd0);
        check("stall_no_ack", 64'(bad_ack), 64'd0);
        check("stall_s_stb_kept", 64'(s_stb), 64'd1);
`endif
        @(posedge clk); #1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("stall_release", 64'(grant), 64'd0);

        repeat (2) @(posedge clk);
        check("ack_queue_drained", 64'(ack_q.size()), 64'd0);
        check("grant_queue_drained", 64'(gnt_q.size()), 64'd0);
        summary();
        $finish;
    end

endmodule
